axi_outstanding_limiter: RTL and testbench

// - Sits directly upstream of the ID-translating port mapper, between the PS-side AXI master and that mapper.
// - The mapper's ID tables hold READ_DEPTH / WRITE_DEPTH entries and have no full check.
// - This block registers the AR and AW channels through 2-entry skid buffers.
// - It counts in-flight reads and writes and withholds AR/AW valid when a table would overflow.

---
 rtl/axi_outstanding_limiter.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_outstanding_limiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_outstanding_limiter.sv
// axi_outstanding_limiter
// Registers the AR and AW channels through 2-entry skid buffers and withholds
// the downstream valid whenever the mapper's ID table for that direction is full.
// Optional build macro: OUTSTANDING_STALL_CNT_EN adds saturating 32-bit stall
// cycle counters (rd_stall_cycles, wr_stall_cycles).

// One address channel: 2-entry FIFO skid buffer, outstanding counter and gate.
module axi_ol_channel #(
  parameter int P_WIDTH   = 69,
  parameter int MAX_OUT   = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P_WIDTH-1:0]   s_payload,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [P_WIDTH-1:0]   m_payload,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 done,
  output logic [CNT_WIDTH-1:0] outstanding
`ifdef OUTSTANDING_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUT);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  logic [P_WIDTH-1:0]   mem_r [2];
  logic                 wr_ptr_r;
  logic                 rd_ptr_r;
  logic [1:0]           occ_r;
  logic [1:0]           occ_s;
  logic                 valid_r;
  logic                 valid_s;
  logic                 ready_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 dec_s;

  // Next occupancy, counter and gated valid; a presented valid is held until accepted.
  always_comb begin
    push_s = s_valid & ready_r;
    pop_s  = valid_r & m_ready;
    // A completion at zero count is a protocol error and is ignored.
    dec_s  = done & (cnt_r != {CNT_WIDTH{1'b0}});
    occ_s  = occ_r;
    cnt_s  = cnt_r;
    valid_s = 1'b0;

    case ({push_s, pop_s})
      2'b10:   occ_s = occ_r + 2'd1;
      2'b01:   occ_s = occ_r - 2'd1;
      default: occ_s = occ_r;
    endcase

    if (pop_s && !dec_s) begin
      if (cnt_r < MAX_CNT) begin
        cnt_s = cnt_r + ONE_CNT;
      end else begin
        cnt_s = cnt_r;
      end
    end else if (dec_s && !pop_s) begin
      cnt_s = cnt_r - ONE_CNT;
    end else begin
      cnt_s = cnt_r;
    end

    // Gate uses the next count so a freed slot re-enables valid one cycle later.
    if (occ_s == 2'd0) begin
      valid_s = 1'b0;
    end else if (valid_r && !pop_s) begin
      valid_s = 1'b1;
    end else begin
      valid_s = (cnt_s < MAX_CNT);
    end
  end

  // Buffer storage, pointers, handshake flags and outstanding counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= {P_WIDTH{1'b0}};
      mem_r[1] <= {P_WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b0;
      cnt_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= s_payload;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r   <= occ_s;
      valid_r <= valid_s;
      ready_r <= (occ_s != 2'd2);
      cnt_r   <= cnt_s;
    end
  end

`ifdef OUTSTANDING_STALL_CNT_EN
  logic [31:0] stall_r;

  // Count cycles a buffered head is held back by a full table; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= 32'd0;
    end else if ((occ_r != 2'd0) && !valid_r && (cnt_r >= MAX_CNT) &&
                 (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end
  end

  assign stall_cycles = stall_r;
`endif

  assign m_payload   = mem_r[rd_ptr_r];
  assign m_valid     = valid_r;
  assign s_ready     = ready_r;
  assign outstanding = cnt_r;
endmodule

module axi_outstanding_limiter #(
  parameter int ID_WIDTH   = 16,
  parameter int ADDR_WIDTH = 40,
  parameter int MAX_READS  = 16,
  parameter int MAX_WRITES = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic [ID_WIDTH-1:0]   s00_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [7:0]            s00_axi_arlen,
  input  logic [2:0]            s00_axi_arsize,
  input  logic [1:0]            s00_axi_arburst,
  input  logic                  s00_axi_arvalid,
  output logic                  s00_axi_arready,
  output logic [ID_WIDTH-1:0]   m00_axi_arid,
  output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [7:0]            m00_axi_arlen,
  output logic [2:0]            m00_axi_arsize,
  output logic [1:0]            m00_axi_arburst,
  output logic                  m00_axi_arvalid,
  input  logic                  m00_axi_arready,
  input  logic [ID_WIDTH-1:0]   s00_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [7:0]            s00_axi_awlen,
  input  logic [2:0]            s00_axi_awsize,
  input  logic [1:0]            s00_axi_awburst,
  input  logic                  s00_axi_awvalid,
  output logic                  s00_axi_awready,
  output logic [ID_WIDTH-1:0]   m00_axi_awid,
  output logic [ADDR_WIDTH-1:0] m00_axi_awaddr,
  output logic [7:0]            m00_axi_awlen,
  output logic [2:0]            m00_axi_awsize,
  output logic [1:0]            m00_axi_awburst,
  output logic                  m00_axi_awvalid,
  input  logic                  m00_axi_awready,
  input  logic                  mon_rvalid,
  input  logic                  mon_rready,
  input  logic                  mon_rlast,
  input  logic                  mon_bvalid,
  input  logic                  mon_bready,
  output logic [CNT_WIDTH-1:0]  rd_outstanding,
  output logic [CNT_WIDTH-1:0]  wr_outstanding
`ifdef OUTSTANDING_STALL_CNT_EN
  ,
  output logic [31:0]           rd_stall_cycles,
  output logic [31:0]           wr_stall_cycles
`endif
);
  localparam int PW = ID_WIDTH + ADDR_WIDTH + 13;

  logic [PW-1:0] ar_m_payload_s;
  logic [PW-1:0] aw_m_payload_s;

  axi_ol_channel #(.P_WIDTH(PW), .MAX_OUT(MAX_READS), .CNT_WIDTH(CNT_WIDTH)) u_ar (
    .clk         (s00_axi_aclk),
    .rst         (s00_axi_areset),
    .s_payload   ({s00_axi_arid, s00_axi_araddr, s00_axi_arlen, s00_axi_arsize, s00_axi_arburst}),
    .s_valid     (s00_axi_arvalid),
    .s_ready     (s00_axi_arready),
    .m_payload   (ar_m_payload_s),
    .m_valid     (m00_axi_arvalid),
    .m_ready     (m00_axi_arready),
    .done        (mon_rvalid & mon_rready & mon_rlast),
    .outstanding (rd_outstanding)
`ifdef OUTSTANDING_STALL_CNT_EN
    ,
    .stall_cycles(rd_stall_cycles)
`endif
  );

  axi_ol_channel #(.P_WIDTH(PW), .MAX_OUT(MAX_WRITES), .CNT_WIDTH(CNT_WIDTH)) u_aw (
    .clk         (s00_axi_aclk),
    .rst         (s00_axi_areset),
    .s_payload   ({s00_axi_awid, s00_axi_awaddr, s00_axi_awlen, s00_axi_awsize, s00_axi_awburst}),
    .s_valid     (s00_axi_awvalid),
    .s_ready     (s00_axi_awready),
    .m_payload   (aw_m_payload_s),
    .m_valid     (m00_axi_awvalid),
    .m_ready     (m00_axi_awready),
    .done        (mon_bvalid & mon_bready),
    .outstanding (wr_outstanding)
`ifdef OUTSTANDING_STALL_CNT_EN
    ,
    .stall_cycles(wr_stall_cycles)
`endif
  );

  assign {m00_axi_arid, m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst} = ar_m_payload_s;
  assign {m00_axi_awid, m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst} = aw_m_payload_s;
endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed testbench for axi_outstanding_limiter.
module tb_axi_outstanding_limiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ar_id = 16'd0;
  logic [39:0] ar_addr = 40'd0;
  logic [7:0]  ar_len = 8'd0;
  logic [2:0]  ar_size = 3'd3;
  logic [1:0]  ar_burst = 2'd1;
  logic        ar_valid = 1'b0;
  logic        s_arready;
  logic [15:0] m_arid;
  logic [39:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [15:0] aw_id = 16'd0;
  logic [39:0] aw_addr = 40'd0;
  logic [7:0]  aw_len = 8'd3;
  logic [2:0]  aw_size = 3'd2;
  logic [1:0]  aw_burst = 2'd1;
  logic        aw_valid = 1'b0;
  logic        s_awready;
  logic [15:0] m_awid;
  logic [39:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic        r_hs = 1'b0;
  logic        b_hs = 1'b0;
  logic [4:0]  rd_out;
  logic [4:0]  wr_out;
`ifdef OUTSTANDING_STALL_CNT_EN
  logic [31:0] rd_stall;
  logic [31:0] wr_stall;
`endif

  int checks = 0;
  int errors = 0;
  int sent;
  int issued;
  logic order_ok;
  logic acc;
  logic mhs;

  always #5 clk = ~clk;

  axi_outstanding_limiter dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_arid    (ar_id),
    .s00_axi_araddr  (ar_addr),
    .s00_axi_arlen   (ar_len),
    .s00_axi_arsize  (ar_size),
    .s00_axi_arburst (ar_burst),
    .s00_axi_arvalid (ar_valid),
    .s00_axi_arready (s_arready),
    .m00_axi_arid    (m_arid),
    .m00_axi_araddr  (m_araddr),
    .m00_axi_arlen   (m_arlen),
    .m00_axi_arsize  (m_arsize),
    .m00_axi_arburst (m_arburst),
    .m00_axi_arvalid (m_arvalid),
    .m00_axi_arready (m_arready),
    .s00_axi_awid    (aw_id),
    .s00_axi_awaddr  (aw_addr),
    .s00_axi_awlen   (aw_len),
    .s00_axi_awsize  (aw_size),
    .s00_axi_awburst (aw_burst),
    .s00_axi_awvalid (aw_valid),
    .s00_axi_awready (s_awready),
    .m00_axi_awid    (m_awid),
    .m00_axi_awaddr  (m_awaddr),
    .m00_axi_awlen   (m_awlen),
    .m00_axi_awsize  (m_awsize),
    .m00_axi_awburst (m_awburst),
    .m00_axi_awvalid (m_awvalid),
    .m00_axi_awready (m_awready),
    .mon_rvalid      (r_hs),
    .mon_rready      (r_hs),
    .mon_rlast       (r_hs),
    .mon_bvalid      (b_hs),
    .mon_bready      (b_hs),
    .rd_outstanding  (rd_out),
    .wr_outstanding  (wr_out)
`ifdef OUTSTANDING_STALL_CNT_EN
    ,
    .rd_stall_cycles (rd_stall),
    .wr_stall_cycles (wr_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_rd_cnt", 64'(rd_out), 64'd0);
    chk("rst_araddr", 64'(m_araddr), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_arready", 64'(s_arready), 64'd1);
    chk("post_rst_awready", 64'(s_awready), 64'd1);

    // Single read, len 0
    m_arready = 1'b1;
    ar_valid = 1'b1;
    ar_id = 16'h1234;
    ar_addr = 40'h12_3456_789A;
    tick();
    ar_valid = 1'b0;
    chk("single_arvalid", 64'(m_arvalid), 64'd1);
    chk("single_arid", 64'(m_arid), 64'h1234);
    chk("single_araddr", 64'(m_araddr), 64'h12_3456_789A);
    chk("single_arsize", 64'(m_arsize), 64'd3);
    tick();
    chk("single_after_hs_valid", 64'(m_arvalid), 64'd0);
    chk("single_rd_cnt1", 64'(rd_out), 64'd1);
    repeat (3) tick();
    chk("single_rd_cnt_hold", 64'(rd_out), 64'd1);
    r_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    chk("single_rd_cnt0", 64'(rd_out), 64'd0);

    // Fill: 18 reads offered, no responses
    sent = 0;
    issued = 0;
    order_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sent < 18) begin
        ar_valid = 1'b1;
        ar_addr = 40'(sent);
        ar_id = 16'(16'h100 + sent);
      end else begin
        ar_valid = 1'b0;
      end
      acc = ar_valid && s_arready;
      mhs = m_arvalid && m_arready;
      if (mhs && (m_araddr != 40'(issued))) order_ok = 1'b0;
      tick();
      if (acc) sent++;
      if (mhs) issued++;
    end
    ar_valid = 1'b0;
    chk("full_sent", 64'(sent), 64'd18);
    chk("full_issued", 64'(issued), 64'd16);
    chk("full_order", 64'(order_ok), 64'd1);
    chk("full_rd_cnt", 64'(rd_out), 64'd16);
    chk("full_arvalid_low", 64'(m_arvalid), 64'd0);
    chk("full_arready_low", 64'(s_arready), 64'd0);
    chk("full_head_addr", 64'(m_araddr), 64'd16);

    // One rlast from the full state releases exactly one beat
    r_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    chk("rel_arvalid", 64'(m_arvalid), 64'd1);
    chk("rel_rd_cnt15", 64'(rd_out), 64'd15);
    chk("rel_araddr", 64'(m_araddr), 64'd16);
    tick();
    chk("rel_rd_cnt16", 64'(rd_out), 64'd16);
    chk("rel_arvalid_low", 64'(m_arvalid), 64'd0);
    chk("rel_next_head", 64'(m_araddr), 64'd17);
    chk("rel_arready", 64'(s_arready), 64'd1);
    tick();
    chk("rel_arvalid_still_low", 64'(m_arvalid), 64'd0);

    // Downstream stall: valid and payload stay constant
    m_arready = 1'b0;
    r_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("hold_arvalid", 64'(m_arvalid), 64'd1);
      chk("hold_araddr", 64'(m_araddr), 64'd17);
      chk("hold_arid", 64'(m_arid), 64'h111);
      tick();
    end
    r_hs = 1'b1;
    repeat (8) tick();
    r_hs = 1'b0;
    chk("drain_rd_cnt7", 64'(rd_out), 64'd7);
    chk("drain_arvalid", 64'(m_arvalid), 64'd1);

    // Simultaneous AR handshake and rlast at count 7
    m_arready = 1'b1;
    r_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    m_arready = 1'b0;
    chk("simul_rd_cnt7", 64'(rd_out), 64'd7);
    chk("simul_arvalid_empty", 64'(m_arvalid), 64'd0);

    // Write path: three back-to-back AWs
    m_awready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aw_valid = 1'b1;
      aw_addr = 40'(32'h200 + i);
      aw_id = 16'(16'h40 + i);
      tick();
    end
    aw_valid = 1'b0;
    repeat (2) tick();
    chk("aw_wr_cnt3", 64'(wr_out), 64'd3);

    // Simultaneous AW handshake and B at count 3
    aw_valid = 1'b1;
    aw_addr = 40'h203;
    aw_id = 16'h43;
    tick();
    aw_valid = 1'b0;
    chk("aw4_valid", 64'(m_awvalid), 64'd1);
    chk("aw4_addr", 64'(m_awaddr), 64'h203);
    chk("aw4_len", 64'(m_awlen), 64'd3);
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    chk("aw_simul_cnt3", 64'(wr_out), 64'd3);
    chk("aw_simul_valid_low", 64'(m_awvalid), 64'd0);

    // Two more issued -> wr_outstanding 5
    for (int i = 4; i < 6; i++) begin
      aw_valid = 1'b1;
      aw_addr = 40'(32'h200 + i);
      tick();
    end
    aw_valid = 1'b0;
    repeat (2) tick();
    chk("aw_wr_cnt5", 64'(wr_out), 64'd5);

    // Two AWs buffered behind a stalled mapper
    m_awready = 1'b0;
    for (int i = 6; i < 8; i++) begin
      aw_valid = 1'b1;
      aw_addr = 40'(32'h200 + i);
      tick();
    end
    aw_valid = 1'b0;
    tick();
    chk("aw_buf_cnt5", 64'(wr_out), 64'd5);
    chk("aw_buf_ready_low", 64'(s_awready), 64'd0);
    chk("aw_buf_valid", 64'(m_awvalid), 64'd1);
    chk("aw_buf_addr", 64'(m_awaddr), 64'h206);

    // Reset mid-burst
    rst = 1'b1;
    tick();
    chk("mid_rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("mid_rst_wr_cnt", 64'(wr_out), 64'd0);
    chk("mid_rst_awaddr", 64'(m_awaddr), 64'd0);
    chk("mid_rst_rd_cnt", 64'(rd_out), 64'd0);
    chk("mid_rst_awready", 64'(s_awready), 64'd0);
    rst = 1'b0;
    tick();
    chk("mid_post_awready", 64'(s_awready), 64'd1);
    chk("mid_post_awvalid", 64'(m_awvalid), 64'd0);

    // Decrement at zero is ignored
    r_hs = 1'b1;
    b_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    b_hs = 1'b0;
    chk("zero_rd_cnt", 64'(rd_out), 64'd0);
    chk("zero_wr_cnt", 64'(wr_out), 64'd0);

`ifdef OUTSTANDING_STALL_CNT_EN
    // 16 reads issued, one more gated for 20 cycles
    m_arready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ar_valid = 1'b1;
      ar_addr = 40'(32'h300 + i);
      tick();
    end
    ar_valid = 1'b0;
    chk("stall_rd_cnt16", 64'(rd_out), 64'd16);
    repeat (20) tick();
    chk("stall_cycles20", 64'(rd_stall), 64'd20);
    chk("stall_wr_zero", 64'(wr_stall), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
